matrix_row_seq: RTL and testbench

Row sequencer for the matrix coprocessor's row-wise ALU stages such as the negation stage. It latches a 5x5 signed 8-bit matrix and issues its rows one per cycle to a row unit of fixed latency. It then gathers the returned rows into a result matrix and signals completion with a one-cycle `done` pulse. The block sits between the coprocessor's matrix register file and any single-row operator.

---
 rtl/matrix_row_seq.sv | 91 +++++++++
 tb/tb_matrix_row_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/matrix_row_seq.sv
// matrix_row_seq: issues a latched matrix row by row to a fixed-latency row unit and gathers the results.
// Optional overflow checker enabled by defining ROW_OVF_CHECK_EN.
module matrix_row_seq #(
  parameter int ROWS  = 5,
  parameter int ROW_W = 40,
  parameter int LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ROWS*ROW_W-1:0] m_in,
  output logic [ROW_W-1:0]      row_out,
  output logic                  row_valid,
  input  logic [ROW_W-1:0]      row_in,
  output logic [ROWS*ROW_W-1:0] m_res,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);
  localparam int IW = $clog2(ROWS + 1);
  localparam logic [IW-1:0] LAST = IW'(ROWS - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state;
  logic [IW-1:0] cnt;
  logic [ROWS*ROW_W-1:0] src, sh;
  logic [IW:0] tag [LAT];
  logic cap;
  logic [IW-1:0] cap_idx;
  // the source buffer shifts up so the next row is always at the top
  assign sh = src << ROW_W;
  assign cap = tag[LAT-1][IW];
  assign cap_idx = tag[LAT-1][IW-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      src <= '0;
      row_out <= '0;
      row_valid <= 1'b0;
      m_res <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      for (int k = 0; k < LAT; k++) tag[k] <= '0;
    end else begin
      // the tag follows each row through the unit so it lands at its own index
      tag[0] <= {row_valid, cnt};
      for (int k = 1; k < LAT; k++) tag[k] <= tag[k-1];
      if (cap) m_res[ROW_W*(ROWS-1-32'(cap_idx)) +: ROW_W] <= row_in;
      case (state)
        IDLE: if (start) begin
          state <= ISSUE;
          src <= m_in;
          row_out <= m_in[ROWS*ROW_W-1 -: ROW_W];
          row_valid <= 1'b1;
          cnt <= '0;
          busy <= 1'b1;
        end
        ISSUE: begin
          src <= sh;
          state <= cnt == LAST ? DRAIN : ISSUE;
          row_out <= cnt == LAST ? '0 : sh[ROWS*ROW_W-1 -: ROW_W];
          row_valid <= cnt != LAST;
          cnt <= cnt == LAST ? '0 : cnt + 1'b1;
        end
        DRAIN: if (cap && cap_idx == LAST) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: begin
          state <= IDLE;
          done <= 1'b0;
        end
      endcase
    end
  end
`ifdef ROW_OVF_CHECK_EN
  logic hit;
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < ROW_W/8; i++) hit = hit | (row_out[8*i +: 8] == 8'h80);
  end
  always_ff @(posedge clk) begin
    if (rst) ovf <= 1'b0;
    else if (state == IDLE && start) ovf <= 1'b0;
    else if (row_valid && hit) ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_matrix_row_seq.sv
// tb_matrix_row_seq: scoreboard bench driving a LAT=1 and a LAT=3 sequencer with a negating row-unit model.
module tb_matrix_row_seq;
`ifdef ROW_OVF_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  localparam int LATS [2] = '{1, 3};
  typedef struct {logic [199:0] m; int c;} exp_t;
  logic clk = 0, rst = 1;
  logic start [2];
  logic [199:0] m_in [2], m_res [2];
  logic [39:0] row_out [2], row_in [2];
  logic row_valid [2], busy [2], done [2], ovf [2];
  logic [39:0] ru1 = '0;
  logic [39:0] ru3 [3] = '{default: '0};
  int cyc = 0, s [2] = '{0, 0}, errs = 0, checks = 0;
  bit act [2] = '{0, 0};
  exp_t q [2][$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_row_seq #(.LAT(1)) u1 (.clk(clk), .rst(rst), .start(start[0]), .m_in(m_in[0]),
    .row_out(row_out[0]), .row_valid(row_valid[0]), .row_in(row_in[0]), .m_res(m_res[0]),
    .busy(busy[0]), .done(done[0]), .ovf(ovf[0]));
  matrix_row_seq #(.LAT(3)) u3 (.clk(clk), .rst(rst), .start(start[1]), .m_in(m_in[1]),
    .row_out(row_out[1]), .row_valid(row_valid[1]), .row_in(row_in[1]), .m_res(m_res[1]),
    .busy(busy[1]), .done(done[1]), .ovf(ovf[1]));

  function automatic logic [39:0] neg(input logic [39:0] r);
    logic [39:0] o;
    for (int i = 0; i < 5; i++) o[8*i +: 8] = 8'(-r[8*i +: 8]);
    return o;
  endfunction

  // row unit model: negation through LAT registers
  always @(posedge clk) begin
    ru1 <= neg(row_out[0]);
    ru3[0] <= neg(row_out[1]);
    ru3[1] <= ru3[0];
    ru3[2] <= ru3[1];
  end
  assign row_in[0] = ru1;
  assign row_in[1] = ru3[2];

  task automatic chk(input string nm, input logic [199:0] got, input logic [199:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  always @(negedge clk)
    for (int d = 0; d < 2; d++) if (!rst) begin
      int rel;
      exp_t e;
      rel = cyc - s[d];
      if (act[d] && rel >= 1) chk($sformatf("busy%0d_c%0d", d, rel), 200'(busy[d]), 200'(rel <= 5 + LATS[d]));
      if (done[d]) begin
        if (!act[d] || q[d].size() == 0) chk($sformatf("spurious_done%0d", d), 200'(done[d]), 200'(0));
        else begin
          e = q[d].pop_front();
          chk($sformatf("m_res%0d", d), m_res[d], e.m);
          chk($sformatf("done_cycle%0d", d), 200'(rel), 200'(e.c));
          act[d] = 0;
        end
      end
    end

  task automatic start_op(input int d, input logic [199:0] m, input logic [199:0] e, input int c);
    start[d] = 1;
    m_in[d] = m;
    s[d] = cyc;
    act[d] = 1;
    q[d].push_back('{e, c});
    @(posedge clk); #1;
    start[d] = 0;
  endtask

  task automatic at_rel(input int d, input int r);
    while (cyc - s[d] < r) begin @(posedge clk); #1; end
    @(negedge clk);
  endtask

  task automatic wait_done(input int d);
    int n = 0;
    while (act[d] && n < 40) begin @(posedge clk); n++; end
    #1;
    if (act[d]) begin
      checks++;
      errs++;
      $display("FAIL timeout%0d: done not seen within %0d cycles", d, n);
      act[d] = 0;
      q[d].delete();
    end
  endtask

  initial begin
    start = '{0, 0};
    m_in = '{'0, '0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_row_out", 200'(row_out[d]), 200'(0));
      chk("rst_row_valid", 200'(row_valid[d]), 200'(0));
      chk("rst_m_res", m_res[d], 200'(0));
      chk("rst_busy", 200'(busy[d]), 200'(0));
      chk("rst_done", 200'(done[d]), 200'(0));
      chk("rst_ovf", 200'(ovf[d]), 200'(0));
    end
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    // basic and reverse at LAT=1
    start_op(0, {40'h0103020500, 160'h0}, {40'hFFFDFEFB00, 160'h0}, 7);
    wait_done(0);
    start_op(0, {40'hFFFDFEFB00, 160'h0}, {40'h0103020500, 160'h0}, 7);
    wait_done(0);
    // latency sweep at LAT=3
    start_op(1, {40'h0101010101, 40'h0202020202, 40'h0303030303, 40'h0404040404, 40'h0505050505},
                {40'hFFFFFFFFFF, 40'hFEFEFEFEFE, 40'hFDFDFDFDFD, 40'hFCFCFCFCFC, 40'hFBFBFBFBFB}, 9);
    wait_done(1);
    // start during an operation is ignored and m_in changes do not leak in
    start_op(0, {40'h0A0B0C0D0E, 40'h0000000001, 120'h0}, {40'hF6F5F4F3F2, 40'h00000000FF, 120'h0}, 7);
    at_rel(0, 3);
    start[0] = 1;
    m_in[0] = {5{40'h1111111111}};
    @(negedge clk);
    start[0] = 0;
    wait_done(0);
    repeat (10) @(posedge clk);
    #1;
    // reset in cycle 4 aborts
    start_op(0, {5{40'h2222222222}}, {5{40'hDEDEDEDEDE}}, 7);
    at_rel(0, 4);
    rst = 1;
    act[0] = 0;
    q[0].delete();
    @(negedge clk);
    rst = 0;
    chk("abort_row_out", 200'(row_out[0]), 200'(0));
    chk("abort_row_valid", 200'(row_valid[0]), 200'(0));
    chk("abort_m_res", m_res[0], 200'(0));
    chk("abort_busy", 200'(busy[0]), 200'(0));
    chk("abort_done", 200'(done[0]), 200'(0));
    chk("abort_ovf", 200'(ovf[0]), 200'(0));
    repeat (12) @(negedge clk);
    @(posedge clk); #1;
    start_op(0, {40'h0000000005, 160'h0}, {40'h00000000FB, 160'h0}, 7);
    wait_done(0);
    // overflow flag
    start_op(0, {80'h0, 40'h0180000000, 80'h0}, {80'h0, 40'hFF80000000, 80'h0}, 7);
    at_rel(0, 3);
    chk("ovf_c3", 200'(ovf[0]), 200'(0));
    @(negedge clk);
    chk("ovf_c4", 200'(ovf[0]), 200'(OVF_EN));
    @(posedge clk); #1;
    wait_done(0);
    chk("ovf_after_done", 200'(ovf[0]), 200'(OVF_EN));
    start_op(0, 200'h0, 200'h0, 7);
    @(negedge clk);
    chk("ovf_cleared", 200'(ovf[0]), 200'(0));
    @(posedge clk); #1;
    wait_done(0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
